// File: rtl/pulse_width_encoder.sv
// Pulse width encoder: converts each modulated intensity beat into a 9-bit
// pulse width through an external lookup table BRAM. The matching phase, the
// framing tags and the full-scale override travel alongside the table access,
// so every beat emerges TABLE_LATENCY+2 cycles after it was sampled.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for the first beat of a frame (counter is 0)
// S_RUN  | inside a frame, cnt_q beats of it accepted so far
module pulse_width_encoder #(
  parameter int DEPTH         = 249,
  parameter int TABLE_LATENCY = 2    // legal range 1..4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  output logic [14:0] TABLE_ADDR,
  input  logic [7:0]  TABLE_DATA,
  output logic [8:0]  PULSE_WIDTH_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic        DOUT_VALID,
  output logic        DOUT_LAST,
  output logic        FRAME_ERR
);

  // Side-band stages from the sampling edge up to the edge that captures
  // TABLE_DATA; the output register adds the final cycle of latency.
  localparam int PIPE = TABLE_LATENCY + 2;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DEPTH - 1);
  localparam logic [15:0]   FULL_SCALE = 16'hFE01;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       err;
    logic       full;
    logic [7:0] phase;
  } beat_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tag_last;
  logic            tag_err;
  beat_t           pipe_q [PIPE];
  logic [7:0]      data_q;

  // Framing state and beat counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; tags the current input beat as last or marks an abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_last = 1'b0;
    tag_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DIN_VALID) begin
          if (DEPTH == 1) begin
            tag_last = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (DIN_VALID) begin
          if (cnt_q == LAST_CNT) begin
            tag_last = 1'b1;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // The abort rides in the slot right after the last accepted beat.
          tag_err = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Table address register; holds between beats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TABLE_ADDR <= '0;
    end else if (DIN_VALID) begin
      TABLE_ADDR <= INTENSITY_IN[15:1];
    end
  end

  // Side-band shift pipeline matching the table access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: DIN_VALID,
                     last:  tag_last,
                     err:   tag_err,
                     full:  DIN_VALID && (INTENSITY_IN == FULL_SCALE),
                     phase: PHASE_IN};
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Capture table read data in step with the last side-band stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= TABLE_DATA;
    end
  end

  // Output register; data outputs only move on valid beats.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PULSE_WIDTH_OUT <= '0;
      PHASE_OUT       <= '0;
      DOUT_VALID      <= 1'b0;
      DOUT_LAST       <= 1'b0;
      FRAME_ERR       <= 1'b0;
    end else begin
      DOUT_VALID <= pipe_q[PIPE-1].valid;
      DOUT_LAST  <= pipe_q[PIPE-1].valid & pipe_q[PIPE-1].last;
      FRAME_ERR  <= pipe_q[PIPE-1].err;
      if (pipe_q[PIPE-1].valid) begin
        PULSE_WIDTH_OUT <= pipe_q[PIPE-1].full ? 9'd256 : {1'b0, data_q};
        PHASE_OUT       <= pipe_q[PIPE-1].phase;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Directed bench for pulse_width_encoder: a default build (TABLE_LATENCY=2)
// and a TABLE_LATENCY=1 build share the same stimulus, each with its own
// behavioural table BRAM holding addr[7:0] ^ table_xor.
module tb_pulse_width_encoder;
  localparam int DEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DIN_VALID = 1'b0;
  logic [15:0] INTENSITY_IN = '0;
  logic [7:0]  PHASE_IN = '0;
  logic [7:0]  table_xor = '0;

  logic [14:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic [8:0]  pw0, pw1;
  logic [7:0]  ph0, ph1;
  logic        v0, v1, l0, l1, e0, e1;

  logic [14:0] rd0 [2];
  logic [14:0] rd1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [8:0] pw;
    logic [7:0] ph;
    logic       last;
  } obeat_t;

  obeat_t q0[$];
  obeat_t q1[$];
  int     err0[$];
  int     orphan_last = 0;

  pulse_width_encoder #(.DEPTH(DEPTH), .TABLE_LATENCY(2)) dut (
    .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN),
    .PHASE_IN(PHASE_IN), .TABLE_ADDR(addr0), .TABLE_DATA(data0),
    .PULSE_WIDTH_OUT(pw0), .PHASE_OUT(ph0), .DOUT_VALID(v0),
    .DOUT_LAST(l0), .FRAME_ERR(e0));

  pulse_width_encoder #(.DEPTH(DEPTH), .TABLE_LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN),
    .PHASE_IN(PHASE_IN), .TABLE_ADDR(addr1), .TABLE_DATA(data1),
    .PULSE_WIDTH_OUT(pw1), .PHASE_OUT(ph1), .DOUT_VALID(v1),
    .DOUT_LAST(l1), .FRAME_ERR(e1));

  always #5 CLK = ~CLK;

  // Table BRAM models: two-cycle and one-cycle read latency.
  always @(posedge CLK) begin
    rd0[0] <= addr0;
    rd0[1] <= rd0[0];
    rd1    <= addr1;
    cyc    <= cyc + 1;
  end
  assign data0 = rd0[1][7:0] ^ table_xor;
  assign data1 = rd1[7:0] ^ table_xor;

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (v0) q0.push_back('{cyc, pw0, ph0, l0});
      if (v1) q1.push_back('{cyc, pw1, ph1, l1});
      if (e0) err0.push_back(cyc);
      if (l0 && !v0) orphan_last++;
      if (l1 && !v1) orphan_last++;
    end
  end

  task automatic clear_queues();
    q0.delete();
    q1.delete();
    err0.delete();
    orphan_last = 0;
  endtask

  // Presents one beat; it is sampled by the next rising edge.
  task automatic drive_beat(input logic [15:0] inten, input logic [7:0] ph);
    @(negedge CLK);
    DIN_VALID    = 1'b1;
    INTENSITY_IN = inten;
    PHASE_IN     = ph;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DIN_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({addr0, pw0, ph0, v0, l0, e0} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {addr0, pw0, ph0, v0, l0, e0});
    end
    n_cmp++;
    if ({addr1, pw1, ph1, v1, l1, e1} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_l1: got %h required 0", {addr1, pw1, ph1, v1, l1, e1});
    end
    RST = 1'b0;
    drive_idle(4);
    n_cmp++;
    if (v0 !== 1'b0 || e0 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: valid=%b err=%b required 0 0", v0, e0);
    end
  endtask

  task automatic test_full_burst();
    int first_edge;
    clear_queues();
    for (int k = 0; k < DEPTH; k++) begin
      drive_beat(16'(2 * k), 8'(k));
      if (k == 0) first_edge = cyc + 1;
    end
    drive_idle(8);
    n_cmp++;
    if (q0.size() != DEPTH) begin
      n_bad++;
      $display("FAIL full_count: got %0d required %0d", q0.size(), DEPTH);
    end
    n_cmp++;
    if (q0.size() > 0 && q0[0].cyc - first_edge != 4) begin
      n_bad++;
      $display("FAIL full_latency: got %0d required 4", q0[0].cyc - first_edge);
    end
    for (int i = 0; i < q0.size() && i < DEPTH; i++) begin
      logic [7:0] kb;
      kb = 8'(i);
      n_cmp++;
      if (q0[i].pw !== {1'b0, kb} || q0[i].ph !== kb || q0[i].last !== (i == DEPTH - 1)
          || q0[i].cyc != q0[0].cyc + i) begin
        n_bad++;
        $display("FAIL full_beat %0d: got pw=%0d ph=%0d last=%b cyc=%0d required pw=%0d ph=%0d last=%b cyc=%0d",
                 i, q0[i].pw, q0[i].ph, q0[i].last, q0[i].cyc, kb, kb, (i == DEPTH - 1), q0[0].cyc + i);
      end
    end
    n_cmp++;
    if (err0.size() != 0 || orphan_last != 0) begin
      n_bad++;
      $display("FAIL full_no_err: got errs=%0d orphan_last=%0d required 0 0", err0.size(), orphan_last);
    end
    n_cmp++;
    if (q1.size() != DEPTH) begin
      n_bad++;
      $display("FAIL l1_count: got %0d required %0d", q1.size(), DEPTH);
    end
    n_cmp++;
    if (q1.size() > 0 && q1[0].cyc - first_edge != 3) begin
      n_bad++;
      $display("FAIL l1_latency: got %0d required 3", q1[0].cyc - first_edge);
    end
    for (int i = 0; i < q1.size() && i < DEPTH; i++) begin
      logic [7:0] kb;
      kb = 8'(i);
      n_cmp++;
      if (q1[i].pw !== {1'b0, kb} || q1[i].ph !== kb || q1[i].last !== (i == DEPTH - 1)) begin
        n_bad++;
        $display("FAIL l1_beat %0d: got pw=%0d ph=%0d last=%b required pw=%0d ph=%0d last=%b",
                 i, q1[i].pw, q1[i].ph, q1[i].last, kb, kb, (i == DEPTH - 1));
      end
    end
  endtask

  task automatic test_override();
    logic [15:0] inten [4];
    logic [8:0]  exp_pw [8];
    inten = '{16'hFE01, 16'hFE00, 16'h0000, 16'h01FF};
    exp_pw = '{9'd256, 9'h000, 9'h000, 9'h0FF, 9'd256, 9'h05A, 9'h05A, 9'h0A5};
    clear_queues();
    for (int i = 0; i < 4; i++) drive_beat(inten[i], 8'(i + 1));
    drive_idle(8);
    table_xor = 8'h5A;
    for (int i = 0; i < 4; i++) drive_beat(inten[i], 8'(i + 5));
    drive_idle(8);
    table_xor = 8'h00;
    n_cmp++;
    if (q0.size() != 8) begin
      n_bad++;
      $display("FAIL override_count: got %0d required 8", q0.size());
    end
    for (int i = 0; i < q0.size() && i < 8; i++) begin
      n_cmp++;
      if (q0[i].pw !== exp_pw[i] || q0[i].ph !== 8'(i + 1) || q0[i].last !== 1'b0) begin
        n_bad++;
        $display("FAIL override_beat %0d: got pw=%0d ph=%0d last=%b required pw=%0d ph=%0d last=0",
                 i, q0[i].pw, q0[i].ph, q0[i].last, exp_pw[i], i + 1);
      end
    end
    n_cmp++;
    if (err0.size() != 2) begin
      n_bad++;
      $display("FAIL override_errs: got %0d required 2", err0.size());
    end
    n_cmp++;
    if (addr0 !== 15'h00FF) begin
      n_bad++;
      $display("FAIL addr_hold: got %h required 00ff", addr0);
    end
  endtask

  task automatic test_short_burst();
    int drop_edge;
    clear_queues();
    for (int i = 0; i < 100; i++) drive_beat(16'(2 * (300 + i)), 8'(300 + i));
    drop_edge = cyc + 2;
    drive_idle(8);
    n_cmp++;
    if (q0.size() != 100) begin
      n_bad++;
      $display("FAIL short_count: got %0d required 100", q0.size());
    end
    for (int i = 0; i < q0.size() && i < 100; i++) begin
      logic [7:0] kb;
      kb = 8'(300 + i);
      n_cmp++;
      if (q0[i].pw !== {1'b0, kb} || q0[i].ph !== kb || q0[i].last !== 1'b0) begin
        n_bad++;
        $display("FAIL short_beat %0d: got pw=%0d ph=%0d last=%b required pw=%0d ph=%0d last=0",
                 i, q0[i].pw, q0[i].ph, q0[i].last, kb, kb);
      end
    end
    n_cmp++;
    if (err0.size() != 1) begin
      n_bad++;
      $display("FAIL short_err_count: got %0d required 1", err0.size());
    end
    n_cmp++;
    if (err0.size() > 0 && err0[0] != drop_edge + 4) begin
      n_bad++;
      $display("FAIL short_err_time: got %0d required %0d", err0[0] - drop_edge, 4);
    end
    clear_queues();
    for (int k = 0; k < DEPTH; k++) drive_beat(16'(2 * k), 8'(k));
    drive_idle(8);
    n_cmp++;
    if (q0.size() != DEPTH) begin
      n_bad++;
      $display("FAIL reframe_count: got %0d required %0d", q0.size(), DEPTH);
    end
    for (int i = 0; i < q0.size() && i < DEPTH; i++) begin
      n_cmp++;
      if (q0[i].last !== (i == DEPTH - 1) || q0[i].pw !== {1'b0, 8'(i)}) begin
        n_bad++;
        $display("FAIL reframe_beat %0d: got last=%b pw=%0d required last=%b pw=%0d",
                 i, q0[i].last, q0[i].pw, (i == DEPTH - 1), i & 255);
      end
    end
    n_cmp++;
    if (err0.size() != 0) begin
      n_bad++;
      $display("FAIL reframe_err: got %0d required 0", err0.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int k = 0; k < 2 * DEPTH; k++) drive_beat(16'(2 * k), 8'(k));
    drive_idle(8);
    n_cmp++;
    if (q0.size() != 2 * DEPTH) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d required %0d", q0.size(), 2 * DEPTH);
    end
    for (int i = 0; i < q0.size() && i < 2 * DEPTH; i++) begin
      logic [7:0] kb;
      logic       el;
      kb = 8'(i);
      el = (i == DEPTH - 1) || (i == 2 * DEPTH - 1);
      n_cmp++;
      if (q0[i].pw !== {1'b0, kb} || q0[i].ph !== kb || q0[i].last !== el
          || q0[i].cyc != q0[0].cyc + i) begin
        n_bad++;
        $display("FAIL b2b_beat %0d: got pw=%0d ph=%0d last=%b cyc=%0d required pw=%0d ph=%0d last=%b cyc=%0d",
                 i, q0[i].pw, q0[i].ph, q0[i].last, q0[i].cyc, kb, kb, el, q0[0].cyc + i);
      end
    end
    n_cmp++;
    if (err0.size() != 0 || orphan_last != 0) begin
      n_bad++;
      $display("FAIL b2b_no_err: got errs=%0d orphan_last=%0d required 0 0", err0.size(), orphan_last);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 119; k++) drive_beat(16'(2 * k), 8'(k));
    @(negedge CLK);
    INTENSITY_IN = 16'(2 * 119);
    PHASE_IN     = 8'(119);
    #2;
    RST       = 1'b1;
    DIN_VALID = 1'b0;
    #1;
    n_cmp++;
    if ({addr0, pw0, ph0, v0, l0, e0} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h required 0", {addr0, pw0, ph0, v0, l0, e0});
    end
    clear_queues();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    drive_idle(10);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0 || err0.size() != 0) begin
      n_bad++;
      $display("FAIL mid_reset_flush: got beats=%0d/%0d errs=%0d required 0 0 0",
               q0.size(), q1.size(), err0.size());
    end
    clear_queues();
    for (int k = 0; k < DEPTH; k++) drive_beat(16'(2 * k), 8'(k));
    drive_idle(8);
    n_cmp++;
    if (q0.size() != DEPTH) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d required %0d", q0.size(), DEPTH);
    end
    for (int i = 0; i < q0.size() && i < DEPTH; i++) begin
      n_cmp++;
      if (q0[i].last !== (i == DEPTH - 1) || q0[i].ph !== 8'(i)) begin
        n_bad++;
        $display("FAIL post_reset_beat %0d: got last=%b ph=%0d required last=%b ph=%0d",
                 i, q0[i].last, q0[i].ph, (i == DEPTH - 1), i & 255);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_override();
    test_short_burst();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_encoder.md
Name: pulse_width_encoder

Overview:
- Stage directly downstream of the modulation multiplier.
- Consumes the per-frame burst of 16-bit modulated intensities (DEPTH beats, one per transducer) and converts each to a 9-bit pulse width through a host-writable lookup table in BRAM.
- Passes the matching phase through with identical latency.
- Feeds the PWM generator stage with framed, valid-qualified pulse width/phase pairs.

Parameters:
- DEPTH, 249, transducers per frame (beats per burst).
- TABLE_LATENCY, 2, BRAM read latency in cycles (address registered to data valid); legal range 1..4.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- DIN_VALID  input  1  qualifies INTENSITY_IN/PHASE_IN, high for DEPTH consecutive cycles per frame.
- INTENSITY_IN  input  16  modulated intensity, 0..65025.
- PHASE_IN  input  8  phase of the same transducer.
- TABLE_ADDR  output  15  lookup address to table BRAM.
- TABLE_DATA  input  8  table read data, valid TABLE_LATENCY cycles after TABLE_ADDR.
- PULSE_WIDTH_OUT  output  9  encoded pulse width, 0..256.
- PHASE_OUT  output  8  delayed PHASE_IN.
- DOUT_VALID  output  1  qualifies PULSE_WIDTH_OUT/PHASE_OUT.
- DOUT_LAST  output  1  high with the DEPTH-th output beat of a frame.
- FRAME_ERR  output  1  one-cycle pulse on an aborted (short) burst.

Behaviour:
- Reset (async, RST=1):
  - All outputs 0: TABLE_ADDR, PULSE_WIDTH_OUT, PHASE_OUT, DOUT_VALID, DOUT_LAST, FRAME_ERR.
  - Pipeline valid bits cleared, beat counter 0, state IDLE.
  - Reset mid-frame discards all in-flight beats; no DOUT_VALID is produced for them after release.
- Address:
  - TABLE_ADDR is registered: INTENSITY_IN[15:1] when DIN_VALID=1.
  - TABLE_ADDR holds its last value otherwise.
- Full-scale override:
  - If INTENSITY_IN == 16'hFE01, the beat is flagged and its output is 9'd256, ignoring TABLE_DATA.
  - Otherwise the output is {1'b0, TABLE_DATA}.
  - INTENSITY_IN == 0 is not special-cased; the table returns its content at address 0.
- Latency:
  - Total latency L = TABLE_LATENCY + 2, i.e. 4 by default.
  - A beat sampled at edge n appears on the outputs after edge n+L.
  - Phase, override flag, valid and last bits travel through a shift pipeline of matching length.
  - Throughput is one beat per cycle; there is no backpressure.
- Framing state machine:
  - IDLE: on DIN_VALID=1, set beat counter to 1 and go to RUN.
  - RUN with DIN_VALID=1:
    - If counter == DEPTH-1, this beat is tagged last, the counter goes to 0 and the state goes to IDLE.
    - Otherwise the counter increments.
  - RUN with DIN_VALID=0 (burst shorter than DEPTH):
    - Pulse FRAME_ERR, timed with the output of the cycle after the last accepted beat, i.e. L cycles after the drop.
    - Go to IDLE and clear the counter.
    - Already-accepted beats still emerge with DOUT_VALID=1; none is tagged last.
  - DEPTH=1: every beat is tagged last and the state stays IDLE.
- Continuous DIN_VALID longer than DEPTH:
  - Beat DEPTH+1 starts a new frame seamlessly, with no bubble.
  - DOUT_LAST marks every DEPTH-th beat.
- DOUT_LAST is only ever high together with DOUT_VALID.
- Outputs hold their last values when DOUT_VALID=0; consumers must not sample them then.

Test Plan:
- Table loaded with addr[7:0]; burst of 249 beats with INTENSITY_IN=2k, PHASE_IN=k -> after 4 cycles, 249 consecutive DOUT_VALID beats with PULSE_WIDTH_OUT=k[7:0], PHASE_OUT=k; DOUT_LAST only on beat 249; FRAME_ERR never asserted.
- INTENSITY_IN=16'hFE01 with TABLE_DATA forced 8'h00 -> PULSE_WIDTH_OUT=9'd256; INTENSITY_IN=16'hFE00 -> {1'b0, table[0x7F00]}.
- DIN_VALID high for 100 cycles then low -> 100 output beats, DOUT_LAST never high, one FRAME_ERR pulse 4 cycles after the drop; the next 249-beat burst is framed correctly.
- DIN_VALID high for 498 consecutive cycles -> 498 contiguous output beats, DOUT_LAST on beats 249 and 498.
- RST asserted at beat 120 for 2 cycles, then a fresh full burst -> outputs 0 immediately on RST; no output beats from the aborted burst; new frame ends with DOUT_LAST on its 249th beat.
- TABLE_LATENCY=1 build -> first DOUT_VALID 3 cycles after first DIN_VALID; values match the first scenario.
